// File: rtl/rgb_pixel_assembler.sv
// Packs an R,G,B byte stream into 24-bit pixels with frame tracking and a sticky framing error.
// Optional build macro: PX_TIMEOUT_EN drops a partial pixel after TIMEOUT_CYCLES idle cycles.
module rgb_pixel_assembler #(
    parameter int MAX_PIXEL_BITS = 24,
    parameter int PX_COUNT_BITS  = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      nreset_i,
    input  logic                      byte_valid_i,
    input  logic [7:0]                byte_i,
    input  logic                      sof_i,
    output logic [MAX_PIXEL_BITS-1:0] px_rgb_o,
    output logic                      px_rdy_o,
    output logic [PX_COUNT_BITS-1:0]  px_count_o,
    output logic                      frame_err_o
);

    typedef enum logic [1:0] {
        WAIT_SOF,
        PH_R,
        PH_G,
        PH_B
    } state_t;

    state_t     state;
    logic [7:0] red;
    logic [7:0] green;
    logic       timeout;

`ifdef PX_TIMEOUT_EN
    localparam int IDLE_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_BITS-1:0] idle;
    logic                 mid_pixel;

    assign mid_pixel = (state == PH_G) || (state == PH_B);
    assign timeout   = mid_pixel && !byte_valid_i
                       && (idle == IDLE_BITS'(TIMEOUT_CYCLES - 1));

    // Idle cycles only accumulate while a pixel is partially assembled.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            idle <= '0;
        end else if (byte_valid_i || timeout || !mid_pixel) begin
            idle <= '0;
        end else begin
            idle <= idle + IDLE_BITS'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state       <= WAIT_SOF;
            red         <= '0;
            green       <= '0;
            px_rgb_o    <= '0;
            px_rdy_o    <= 1'b0;
            px_count_o  <= '0;
            frame_err_o <= 1'b0;
        end else begin
            px_rdy_o <= 1'b0;
            if (byte_valid_i) begin
                case (state)
                    WAIT_SOF: begin
                        if (sof_i) begin
                            red         <= byte_i;
                            px_count_o  <= '0;
                            frame_err_o <= 1'b0;
                            state       <= PH_G;
                        end
                    end
                    PH_R: begin
                        red   <= byte_i;
                        state <= PH_G;
                        if (sof_i) begin
                            px_count_o  <= '0;
                            frame_err_o <= 1'b0;
                        end
                    end
                    PH_G: begin
                        // A frame start here abandons the partial pixel and restarts on this byte.
                        if (sof_i) begin
                            red         <= byte_i;
                            px_count_o  <= '0;
                            frame_err_o <= 1'b1;
                            state       <= PH_G;
                        end else begin
                            green <= byte_i;
                            state <= PH_B;
                        end
                    end
                    PH_B: begin
                        if (sof_i) begin
                            red         <= byte_i;
                            px_count_o  <= '0;
                            frame_err_o <= 1'b1;
                            state       <= PH_G;
                        end else begin
                            px_rgb_o <= {red, green, byte_i};
                            px_rdy_o <= 1'b1;
                            if (px_count_o != '1) begin
                                px_count_o <= px_count_o + 1'b1;
                            end
                            state <= PH_R;
                        end
                    end
                    default: state <= WAIT_SOF;
                endcase
            end else if (timeout) begin
                frame_err_o <= 1'b1;
                state       <= PH_R;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pixel_assembler.sv
// Directed scoreboard bench for rgb_pixel_assembler; a second instance with a 2-bit counter
// exercises count saturation. Built with PX_TIMEOUT_EN it also exercises the idle timeout.
module tb_rgb_pixel_assembler;

    logic        clk_i;
    logic        nreset_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        sof_i;
    logic [23:0] px_rgb_o;
    logic        px_rdy_o;
    logic [15:0] px_count_o;
    logic        frame_err_o;
    logic [23:0] sat_rgb;
    logic        sat_rdy;
    logic [1:0]  sat_count;
    logic        sat_err;

    typedef struct {
        logic [23:0] rgb;
        logic [15:0] count;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_rdy = 1'b0;

    rgb_pixel_assembler #(.MAX_PIXEL_BITS(24), .PX_COUNT_BITS(16), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .nreset_i(nreset_i), .byte_valid_i(byte_valid_i),
        .byte_i(byte_i), .sof_i(sof_i), .px_rgb_o(px_rgb_o), .px_rdy_o(px_rdy_o),
        .px_count_o(px_count_o), .frame_err_o(frame_err_o)
    );

    rgb_pixel_assembler #(.MAX_PIXEL_BITS(24), .PX_COUNT_BITS(2), .TIMEOUT_CYCLES(4)) dut_sat (
        .clk_i(clk_i), .nreset_i(nreset_i), .byte_valid_i(byte_valid_i),
        .byte_i(byte_i), .sof_i(sof_i), .px_rgb_o(sat_rgb), .px_rdy_o(sat_rdy),
        .px_count_o(sat_count), .frame_err_o(sat_err)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic sof);
        byte_valid_i = 1'b1;
        byte_i       = b;
        sof_i        = sof;
        @(posedge clk_i);
        #1;
        byte_valid_i = 1'b0;
        sof_i        = 1'b0;
        byte_i       = 8'hxx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic expect_px(input logic [23:0] rgb, input logic [15:0] count, input logic err);
        exp_t e;
        e.rgb   = rgb;
        e.count = count;
        e.err   = err;
        q.push_back(e);
    endtask

    task automatic do_reset();
        nreset_i = 1'b0;
        idle(2);
        nreset_i = 1'b1;
    endtask

    // Every strobe must match the oldest pending expectation and last exactly one cycle.
    always @(negedge clk_i) begin
        if (px_rdy_o) begin
            exp_t e;
            check("strobe_expected", 32'(q.size() != 0), 32'd1);
            check("strobe_single_cycle", 32'(prev_rdy), 32'd0);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("px_rgb", 32'(px_rgb_o), 32'(e.rgb));
                check("px_count", 32'(px_count_o), 32'(e.count));
                check("frame_err", 32'(frame_err_o), 32'(e.err));
            end
        end
        prev_rdy <= px_rdy_o;
    end

    initial begin
        nreset_i     = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        sof_i        = 1'b0;
        idle(1);

        // Reset values
        do_reset();
        check("reset_rgb", 32'(px_rgb_o), 32'h0);
        check("reset_rdy", 32'(px_rdy_o), 32'h0);
        check("reset_count", 32'(px_count_o), 32'h0);
        check("reset_err", 32'(frame_err_o), 32'h0);

        // Back-to-back pixel
        send(8'h12, 1'b1);
        send(8'h34, 1'b0);
        expect_px(24'h123456, 16'd1, 1'b0);
        send(8'h56, 1'b0);
        check("t1_rdy_now", 32'(px_rdy_o), 32'h1);
        idle(1);
        check("t1_rdy_drop", 32'(px_rdy_o), 32'h0);
        check("t1_rgb_hold", 32'(px_rgb_o), 32'h123456);

        // Reset mid-pixel, then bytes without SOF are ignored
        send(8'h77, 1'b0);
        do_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        idle(2);
        check("t2_count_zero", 32'(px_count_o), 32'h0);
        check("t2_rgb_zero", 32'(px_rgb_o), 32'h0);
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        expect_px(24'h010203, 16'd1, 1'b0);
        send(8'h03, 1'b0);

        // Gaps between bytes; SOF in PH_R restarts the count
        send(8'hFF, 1'b1);
        idle(3);
        send(8'h00, 1'b0);
        idle(5);
        expect_px(24'hFF0080, 16'd1, 1'b0);
        send(8'h80, 1'b0);
        idle(3);
        check("t3_rgb_hold", 32'(px_rgb_o), 32'hFF0080);
        check("t3_rdy_low", 32'(px_rdy_o), 32'h0);

        // Second pixel of the frame, then SOF landing on the B byte
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        expect_px(24'hA1A2A3, 16'd2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        check("t4_err_set", 32'(frame_err_o), 32'h1);
        check("t4_count_clear", 32'(px_count_o), 32'h0);
        send(8'h44, 1'b0);
        expect_px(24'h334455, 16'd1, 1'b1);
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        check("t4_err_cleared", 32'(frame_err_o), 32'h0);
        send(8'h77, 1'b0);
        expect_px(24'h667788, 16'd1, 1'b0);
        send(8'h88, 1'b0);

        // SOF landing on the G byte
        send(8'hC1, 1'b0);
        send(8'hD1, 1'b1);
        send(8'hD2, 1'b0);
        expect_px(24'hD1D2D3, 16'd1, 1'b1);
        send(8'hD3, 1'b0);

`ifdef PX_TIMEOUT_EN
        do_reset();
        send(8'h10, 1'b1);
        send(8'h20, 1'b0);
        idle(3);
        check("to_err_before", 32'(frame_err_o), 32'h0);
        idle(1);
        check("to_err_set", 32'(frame_err_o), 32'h1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        expect_px(24'h010203, 16'd1, 1'b1);
        send(8'h03, 1'b0);
`else
        // Without the timeout a partial pixel waits indefinitely
        do_reset();
        send(8'h10, 1'b1);
        send(8'h20, 1'b0);
        idle(20);
        check("wait_err_clear", 32'(frame_err_o), 32'h0);
        expect_px(24'h102030, 16'd1, 1'b0);
        send(8'h30, 1'b0);
`endif

        // Saturating counter on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] sat_exp;
            sat_exp = (i < 3) ? 2'(i + 1) : 2'd3;
            send(8'(i * 3 + 1), (i == 0));
            send(8'(i * 3 + 2), 1'b0);
            expect_px({8'(i * 3 + 1), 8'(i * 3 + 2), 8'(i * 3 + 3)}, 16'(i + 1), 1'b0);
            send(8'(i * 3 + 3), 1'b0);
            check($sformatf("sat_count_%0d", i), 32'(sat_count), 32'(sat_exp));
        end

        idle(3);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pixel_assembler.md
# rgb_pixel_assembler

Byte-stream front end for the grayscale path. It collects incoming 8-bit bytes in R, G, B order and packs each group into one 24-bit RGB pixel. Each completed pixel is presented with a one-cycle ready strobe, the same pixel/ready pair that `gray_scale_core` consumes on `in_px_rgb_i` / `px_rdy_i`. The block also tracks frame start, counts pixels per frame and flags malformed pixels.

## Interface
Parameters:
- `MAX_PIXEL_BITS`, 24 (from `parameters.svh`): packed pixel width. Must equal 24 (three 8-bit channels).
- `PX_COUNT_BITS`, 16: width of the per-frame pixel counter.
- `TIMEOUT_CYCLES`, 255: idle-cycle limit inside a partial pixel. Used only with `PX_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1: single clock; all logic on posedge.
- `nreset_i`  in  1: reset; synchronous, active-low.
- `byte_valid_i`  in  1: `byte_i` is valid this cycle; the byte is accepted on the same edge.
- `byte_i`  in  8: channel byte.
- `sof_i`  in  1: start of frame, qualified by `byte_valid_i`. Marks the red byte of the first pixel.
- `px_rgb_o`  out  `MAX_PIXEL_BITS`: packed pixel, {R[23:16], G[15:8], B[7:0]}.
- `px_rdy_o`  out  1: one-cycle strobe; `px_rgb_o` is valid.
- `px_count_o`  out  `PX_COUNT_BITS`: pixels emitted since the last accepted SOF; saturating.
- `frame_err_o`  out  1: sticky error flag.

## Operation
- States: WAIT_SOF, PH_R, PH_G, PH_B. Reset enters WAIT_SOF.
- WAIT_SOF:
  - Bytes without `sof_i` are ignored.
  - A byte with `sof_i` is latched as R, `px_count_o` clears to 0, `frame_err_o` clears, and the state moves to PH_G.
- PH_R: an accepted byte is latched as R and the state moves to PH_G. If `sof_i` is set, the counter and error flag clear as in WAIT_SOF.
- PH_G: an accepted byte is latched as G and the state moves to PH_B.
- PH_B: an accepted byte completes the pixel:
  - registers `px_rgb_o <= {R, G, byte_i}` and `px_rdy_o <= 1`;
  - increments `px_count_o`, holding at all-ones;
  - moves to PH_R.
- `sof_i` with a valid byte in PH_G or PH_B (mid-pixel frame start):
  - the partial pixel is discarded and no strobe is issued;
  - `frame_err_o` is set;
  - the byte is latched as R of the new frame and `px_count_o` clears to 0;
  - the state moves to PH_G. The error stays set, because the flag clears only on a SOF accepted in WAIT_SOF or PH_R.
- `px_rgb_o` holds its last pixel until the next pixel completes. `px_rdy_o` is 0 in every cycle other than the strobe cycle.
- No backpressure: downstream must accept one pixel per strobe. Pixel rate is at most one per 3 cycles.

## Timing
- Reset values: `px_rgb_o` = 0, `px_rdy_o` = 0, `px_count_o` = 0, `frame_err_o` = 0, state = WAIT_SOF, channel registers = 0.
- Latency: B byte accepted at edge N → `px_rdy_o` = 1 and `px_rgb_o`/`px_count_o` updated after edge N, for exactly one cycle.
- Gaps of any length between bytes are allowed, subject to `PX_TIMEOUT_EN`.
- Reset asserted mid-pixel: the partial pixel is lost, all outputs take reset values on that edge, and a new SOF is required.
- `byte_valid_i` = 0: `sof_i` and `byte_i` are don't-care.

## Configuration
- `PX_TIMEOUT_EN` defined:
  - An idle counter clears on every accepted byte and counts cycles without `byte_valid_i` in PH_G and PH_B.
  - At the cycle where the count reaches `TIMEOUT_CYCLES`, the partial pixel is dropped, `frame_err_o` is set, the state moves to PH_R and the counter clears.
  - The counter is held at 0 in WAIT_SOF and PH_R.
- `PX_TIMEOUT_EN` undefined: no counter is built, a partial pixel waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset, then consecutive bytes 0x12 (with `sof_i`), 0x34, 0x56 → `px_rgb_o` = 0x123456 with a single-cycle `px_rdy_o` one cycle after the 0x56 byte; `px_count_o` = 1; `frame_err_o` = 0.
- After reset, bytes 0xAA, 0xBB, 0xCC without `sof_i` → no strobe, `px_count_o` = 0; then SOF 0x01, 0x02, 0x03 → pixel 0x010203.
- SOF 0xFF, 3 idle cycles, 0x00, 5 idle cycles, 0x80 → one strobe with 0xFF0080; `px_rgb_o` holds 0xFF0080 afterward.
- After two pixels, send R 0x11, G 0x22, then `sof_i` with 0x33, then 0x44, 0x55 → no strobe for the partial pixel; `frame_err_o` = 1; pixel 0x334455; `px_count_o` = 1. A SOF at the next pixel boundary clears `frame_err_o`.
- `PX_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4: SOF 0x10, 0x20, then 4 idle cycles → `frame_err_o` = 1, no strobe; then 0x01, 0x02, 0x03 → pixel 0x010203.
- `PX_COUNT_BITS` = 2: SOF followed by 5 complete pixels → `px_count_o` reads 1, 2, 3, 3, 3.
